// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 OLED SPI driver.
// Holds the controller states and the fixed panel init sequence.
package oled_pkg;

  typedef enum logic [2:0] {
    PANEL_RESET,
    STARTUP,
    LOAD_CMD,
    LOAD_PIX,
    SHIFT,
    BYTE_DONE
  } oled_state_t;

  localparam int INIT_LEN     = 14;
  localparam int SCREEN_BYTES = 1024;

  // Display off, horizontal addressing, full column/page windows,
  // charge pump on, segment/COM remap, display on.
  localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{
    8'hAE, 8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22,
    8'h00, 8'h07, 8'h8D, 8'h14, 8'hA1, 8'hC8, 8'hAF
  };

  // Out-of-range indices return the SSD1306 NOP command.
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    if (int'(idx) < INIT_LEN) return INIT_SEQ[idx];
    return 8'hE3;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 SPI byte shifter, MSB first, SCLK_DIV clk cycles per SCLK half-period.
// io_sdin only moves on the same edge that drops io_sclk, so data is stable around every rising edge.
module spi_byte_tx #(
  parameter int SCLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       io_sclk,
  output logic       io_sdin
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;

  // Last cycle of bit 0's high phase.
  assign done = busy && io_sclk && (bit_cnt == 3'd0) && (div_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      busy    <= 1'b0;
      io_sclk <= 1'b0;
      io_sdin <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      io_sdin <= data[7];
      io_sclk <= 1'b0;
      bit_cnt <= 3'd7;
      div_cnt <= DIV_LAST;
      busy    <= 1'b1;
    end else if (busy) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= DIV_LAST;
        if (!io_sclk) begin
          io_sclk <= 1'b1;
        end else begin
          io_sclk <= 1'b0;
          if (bit_cnt == 3'd0) begin
            busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
            io_sdin <= shreg[6];
          end
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 128x64 driver: panel power-up, init command stream, then endless frame refresh.
// Frame completions (frameNumber) are the system timebase.
module oled_spi_driver
  import oled_pkg::*;
#(
  parameter int SCLK_DIV     = 4,
  parameter int RESET_CYCLES = 270_000,
  parameter int STARTUP_WAIT = 2_700_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] patternByte,
  output logic [9:0] pixelIndex,
  output logic [7:0] frameNumber,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       io_reset
);

  localparam logic [31:0] RESET_LAST   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_WAIT - 1);

  oled_state_t state, next_state;
  logic [31:0] wait_cnt;
  logic [3:0]  cmd_idx;
  logic        tx_load, tx_busy, tx_done;
  logic [7:0]  tx_data;

  spi_byte_tx #(.SCLK_DIV(SCLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load    (tx_load),
    .data    (tx_data),
    .busy    (tx_busy),
    .done    (tx_done),
    .io_sclk (io_sclk),
    .io_sdin (io_sdin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PANEL_RESET;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_load    = 1'b0;
    tx_data    = init_byte(cmd_idx);
    case (state)
      PANEL_RESET: if (wait_cnt == '0) next_state = STARTUP;
      STARTUP:     if (wait_cnt == '0) next_state = LOAD_CMD;
      LOAD_CMD: begin
        tx_load    = 1'b1;
        next_state = SHIFT;
      end
      LOAD_PIX: begin
        tx_load    = 1'b1;
        tx_data    = patternByte;
        next_state = SHIFT;
      end
      // A shifter that went idle without a done pulse still closes the byte.
      SHIFT:       if (tx_done || !tx_busy) next_state = BYTE_DONE;
      BYTE_DONE: begin
        if (io_dc || cmd_idx == 4'(INIT_LEN - 1)) next_state = LOAD_PIX;
        else                                     next_state = LOAD_CMD;
      end
      default:     next_state = PANEL_RESET;
    endcase
  end

  // Pin levels are registered from next_state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= RESET_LAST;
      cmd_idx     <= '0;
      pixelIndex  <= '0;
      frameNumber <= '0;
      io_reset    <= 1'b0;
      io_cs       <= 1'b1;
      io_dc       <= 1'b0;
    end else begin
      io_reset <= (next_state != PANEL_RESET);
      io_cs    <= !(next_state inside {LOAD_CMD, LOAD_PIX, SHIFT});
      case (next_state)
        LOAD_CMD: io_dc <= 1'b0;
        LOAD_PIX: io_dc <= 1'b1;
        default:  ;
      endcase
      case (state)
        PANEL_RESET: wait_cnt <= (wait_cnt == '0) ? STARTUP_LAST : wait_cnt - 32'd1;
        STARTUP: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 32'd1;
          else                cmd_idx  <= '0;
        end
        BYTE_DONE: begin
          if (!io_dc) begin
            cmd_idx <= cmd_idx + 4'd1;
          end else if (pixelIndex == 10'(SCREEN_BYTES - 1)) begin
            pixelIndex  <= '0;
            frameNumber <= frameNumber + 8'd1;
          end else begin
            pixelIndex <= pixelIndex + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/oled_spi_driver.md
# oled_spi_driver

Drives the 128x64 SSD1306 OLED over a 4-wire write-only SPI link and is the display-side stage that consumes `patternByte`. Runs panel power-up, streams a fixed init command sequence, then refreshes the full 1024-byte frame buffer forever. Supplies `pixelIndex` and `frameNumber` to `pattern_generator` and serialises the byte it returns. The frame cadence it generates is the game's only timebase.

## Interface

**Parameters**
- `SCLK_DIV`, default 4: `clk` cycles per SCLK half-period; minimum 1.
- `RESET_CYCLES`, default 270_000: cycles `io_reset` is held low after `rst` (10 ms at 27 MHz).
- `STARTUP_WAIT`, default 2_700_000: cycles waited after releasing `io_reset` before the first command (100 ms).

**Ports**
- `clk` (in, 1): 27 MHz system clock.
- `rst` (in, 1): asynchronous, active-high reset.
- `patternByte` (in, 8): page byte for the current `pixelIndex`; bit 0 is the top pixel of the page.
- `pixelIndex` (out, 10): byte address, 0..1023. Page = `pixelIndex / 128`, column = `pixelIndex % 128`.
- `frameNumber` (out, 8): completed-frame count, wraps 255→0.
- `io_sclk` (out, 1): SPI clock, mode 0.
- `io_sdin` (out, 1): SPI data, MSB first.
- `io_cs` (out, 1): chip select, active low.
- `io_dc` (out, 1): 0 = command, 1 = data.
- `io_reset` (out, 1): panel reset, active low.

## Operation

**Reset values:** `io_reset`=0, `io_cs`=1, `io_sclk`=0, `io_sdin`=0, `io_dc`=0, `pixelIndex`=0, `frameNumber`=0. The FSM enters PANEL_RESET. All outputs are registered.

**FSM states and transitions**
- **PANEL_RESET:** hold `io_reset`=0 for `RESET_CYCLES`, then → STARTUP.
- **STARTUP:** `io_reset`=1 and wait `STARTUP_WAIT` cycles, then → LOAD_CMD with the command index at 0.
- **LOAD_CMD:** load `INIT_SEQ[idx]`, set `io_dc`=0, then → SHIFT.
- **LOAD_PIX:** capture `patternByte`, set `io_dc`=1, then → SHIFT.
- **SHIFT:** `io_cs`=0. For each of 8 bits:
  - drive `io_sdin` while `io_sclk`=0 for `SCLK_DIV` cycles;
  - raise `io_sclk` for `SCLK_DIV` cycles.
  - After bit 0's high phase, drive `io_sclk` low, then → BYTE_DONE.
- **BYTE_DONE:** `io_cs`=1 for exactly one cycle.
  - Command phase: increment idx. After the last init byte (idx 13) → LOAD_PIX; otherwise → LOAD_CMD.
  - Pixel phase: if `pixelIndex`==1023, set `pixelIndex` to 0, increment `frameNumber`, → LOAD_PIX. Otherwise increment `pixelIndex` and → LOAD_PIX.

**Addressing and frame rules**
- The panel runs in horizontal addressing mode with full column and page windows, so it wraps to (0,0) on its own. No per-frame re-addressing.
- Init is never repeated unless `rst` is asserted.
- `rst` asserted at any point, including mid-byte, returns the block to reset values immediately. A partially shifted byte is discarded; the panel-side reset clears any partial command.

## Timing

- **Byte period:** 2 + 16·`SCLK_DIV` cycles (LOAD + 8 bits + BYTE_DONE). With the default, that is 66 cycles.
- **Frame period:** 1024 byte periods. With the default, 67_584 cycles, about 399.5 Hz.
- **`pixelIndex` stability:** stable from its BYTE_DONE update until the next BYTE_DONE. `patternByte` is sampled in LOAD_PIX, one full cycle after the index changes, so a combinational lookup in the consumer has one cycle to settle.
- **`frameNumber` update:** changes in the same cycle that `pixelIndex` wraps to 0, and never at any other time. It is registered and glitch-free because `frameNumber[0]` is used as an edge downstream.
- **SPI timing:** `io_sdin` changes only while `io_sclk`=0. At least `SCLK_DIV` cycles of setup before the rising edge and `SCLK_DIV` cycles of hold after it.
- **First data byte:** starts `RESET_CYCLES` + `STARTUP_WAIT` + 14·(2+16·`SCLK_DIV`) cycles after `rst` deasserts.

## Structure

- **Package `oled_pkg`** holds:
  - the FSM state enum;
  - `INIT_LEN`=14;
  - `INIT_SEQ`: AE, 20, 00, 21, 00, 7F, 22, 00, 07, 8D, 14, A1, C8, AF;
  - `SCREEN_BYTES`=1024.
- **Sub-module `spi_byte_tx`:** one sub-module for the shifter and SCLK divider. Interface: load strobe, 8-bit data, busy/done pulse, plus `io_sclk` and `io_sdin`. The top-level FSM owns `io_cs`, `io_dc` and the counters.

## Test plan

Run with `SCLK_DIV`=1, `RESET_CYCLES`=4, `STARTUP_WAIT`=8.

1. **Reset and power-up:** assert `rst` → all outputs at reset values. Release → `io_reset` stays 0 for 4 cycles, then 1. `io_cs` stays 1 for 8 more cycles.
2. **Init capture:** SPI monitor with `io_dc`=0 → exactly the 14 bytes AE…AF in order, 18 cycles each, `io_cs` high for one cycle between bytes.
3. **Pixel stream:** `patternByte` = `pixelIndex[7:0]` → data bytes 00, 01 … FF, 00 … with `io_dc`=1. Each byte equals the index at its LOAD cycle.
4. **Frame wrap:** after byte 1023 → `pixelIndex`=0 and `frameNumber` 0→1 in the same cycle. Force `frameNumber` 255 → it wraps to 0.
5. **Mid-byte reset:** assert `rst` during bit 3 of a data byte → next cycle has `io_cs`=1, `io_sclk`=0, `io_reset`=0. After release, the full init sequence repeats.
6. **SPI timing:** on every `io_sclk` rising edge, check `io_sdin` unchanged for ≥1 cycle before and after the edge.
